// File: rtl/key_encoder_83.sv
// key_encoder_83: synchronize, debounce and priority-encode eight active-low keys into code/valid with event pulses.
module key_encoder_83 #(
  parameter int CLK_HZ      = 12000000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] keys_n,
  output logic [7:0] keys_db,
  output logic [2:0] code,
  output logic       valid,
  output logic       strobe,
  output logic       key_release
);
  localparam int T  = CLK_HZ / 1000;
  localparam int TW = $clog2(T + 1);
  localparam int CW = $clog2(DEBOUNCE_MS) + 1;
  logic [7:0]    sync1, sync2, raw;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [CW-1:0] cnt [8];
  logic [2:0]    nxt_code;
  logic          nxt_valid;
  assign raw  = ~sync2;
  assign tick = tick_cnt == TW'(T - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync1 <= '1;
      sync2 <= '1;
      tick_cnt <= '0;
    end else begin
      sync1 <= keys_n;
      sync2 <= sync1;
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
    end
  // Any cycle where raw agrees with the debounced state restarts the count.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      keys_db <= '0;
      for (int k = 0; k < 8; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 8; k++)
        if (raw[k] == keys_db[k]) cnt[k] <= '0;
        else if (tick && cnt[k] == CW'(DEBOUNCE_MS - 1)) begin
          keys_db[k] <= raw[k];
          cnt[k] <= '0;
        end else if (tick) cnt[k] <= cnt[k] + CW'(1);
    end
  always_comb begin
    nxt_code = code;
    for (int k = 0; k < 8; k++) if (keys_db[k]) nxt_code = 3'(k);
    nxt_valid = |keys_db;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      code <= '0;
      valid <= 1'b0;
      strobe <= 1'b0;
      key_release <= 1'b0;
    end else begin
      code <= nxt_code;
      valid <= nxt_valid;
      strobe <= nxt_valid && (!valid || nxt_code != code);
      key_release <= valid && !nxt_valid;
    end
endmodule

// File: tb/tb_key_encoder_83.sv
// tb_key_encoder_83: directed scenarios plus randomized key activity checked against a cycle reference model.
module tb_key_encoder_83;
  localparam int CLK_HZ = 4000;
  localparam int DB     = 3;
  localparam int T      = CLK_HZ / 1000;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] keys_n = '1;
  logic [7:0] keys_db;
  logic [2:0] code;
  logic       valid, strobe, key_release;
  int n_chk = 0, n_fail = 0, n_stb = 0, n_rel = 0;

  key_encoder_83 #(.CLK_HZ(CLK_HZ), .DEBOUNCE_MS(DB)) dut (
    .clk(clk), .rst(rst), .keys_n(keys_n), .keys_db(keys_db),
    .code(code), .valid(valid), .strobe(strobe), .key_release(key_release)
  );

  always #5 clk = ~clk;

  // Reference model: keys pass a 2-cycle delay line, a key flips after it has
  // disagreed with its debounced state on DB consecutive ms ticks.
  logic [7:0] m_h1, m_h2, m_db, m_raw;
  int         m_ph, m_hi;
  int         m_cnt [8];
  logic [2:0] m_code;
  logic       m_val, m_stb, m_rel, m_tk;
  always_comb begin
    m_raw = ~m_h2;
    m_tk = m_ph == T - 1;
    m_hi = -1;
    for (int k = 0; k < 8; k++) if (m_db[k]) m_hi = k;
  end
  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_h1 <= '1; m_h2 <= '1; m_db <= '0; m_ph <= 0;
      m_code <= '0; m_val <= 1'b0; m_stb <= 1'b0; m_rel <= 1'b0;
      for (int k = 0; k < 8; k++) m_cnt[k] <= 0;
    end else begin
      m_h1 <= keys_n;
      m_h2 <= m_h1;
      m_ph <= m_tk ? 0 : m_ph + 1;
      m_val <= m_hi >= 0;
      if (m_hi >= 0) m_code <= 3'(m_hi);
      m_stb <= m_hi >= 0 && (!m_val || m_hi != int'(m_code));
      m_rel <= m_val && m_hi < 0;
      for (int k = 0; k < 8; k++)
        if (m_raw[k] == m_db[k]) m_cnt[k] <= 0;
        else if (m_tk && m_cnt[k] == DB - 1) begin
          m_db[k] <= m_raw[k];
          m_cnt[k] <= 0;
        end else if (m_tk) m_cnt[k] <= m_cnt[k] + 1;
    end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (strobe) n_stb++;
      if (key_release) n_rel++;
    end
  endtask

  task automatic do_reset();
    keys_n = '1;
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(1);
  endtask

  task automatic test_reset();
    keys_n = '1;
    rst = 1'b0;
    cyc(2);
    n_chk++; if (keys_db !== 8'h00) begin n_fail++; $display("FAIL reset_keys_db got %h want 00", keys_db); end
    n_chk++; if (code !== 3'd0) begin n_fail++; $display("FAIL reset_code got %0d want 0", code); end
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
    n_chk++; if (strobe !== 1'b0 || key_release !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got %b%b want 00", strobe, key_release); end
    rst = 1'b1;
    cyc(1);
  endtask

  task automatic test_single_key();
    int n;
    n_stb = 0;
    keys_n[5] = 1'b0;
    n = 0;
    while (!keys_db[5] && n < 40) begin cyc(); n++; end
    n_chk++; if (n < 11 || n > 14) begin n_fail++; $display("FAIL single_latency got %0d want 11..14", n); end
    cyc();
    n_chk++; if (code !== 3'd5 || valid !== 1'b1 || strobe !== 1'b1) begin n_fail++; $display("FAIL single_out got code=%0d valid=%b strobe=%b want 5 1 1", code, valid, strobe); end
    cyc(10);
    n_chk++; if (n_stb != 1) begin n_fail++; $display("FAIL single_strobes got %0d want 1", n_stb); end
  endtask

  task automatic test_bounce();
    bit seen;
    do_reset();
    n_stb = 0; n_rel = 0; seen = 0;
    for (int p = 0; p < 45; p++) begin
      keys_n[3] = (p < 6) ? 1'b0 : (p < 9) ? 1'b1 : (p < 15) ? 1'b0 : 1'b1;
      cyc();
      if (keys_db !== 8'h00 || valid !== 1'b0) seen = 1;
    end
    n_chk++; if (seen) begin n_fail++; $display("FAIL bounce_db got changed want stable 00"); end
    n_chk++; if (n_stb != 0 || n_rel != 0) begin n_fail++; $display("FAIL bounce_pulses got strobe=%0d release=%0d want 0 0", n_stb, n_rel); end
  endtask

  task automatic test_priority();
    int n;
    keys_n[2] = 1'b0;
    n = 0;
    while (!(valid && code == 3'd2) && n < 40) begin cyc(); n++; end
    n_chk++; if (code !== 3'd2 || valid !== 1'b1) begin n_fail++; $display("FAIL prio_first got code=%0d valid=%b want 2 1", code, valid); end
    n_stb = 0;
    keys_n[6] = 1'b0;
    n = 0;
    while (code != 3'd6 && n < 40) begin cyc(); n++; end
    cyc(5);
    n_chk++; if (code !== 3'd6 || n_stb != 1) begin n_fail++; $display("FAIL prio_up got code=%0d strobes=%0d want 6 1", code, n_stb); end
    n_stb = 0; n_rel = 0;
    keys_n[6] = 1'b1;
    n = 0;
    while (code != 3'd2 && n < 40) begin cyc(); n++; end
    cyc(5);
    n_chk++; if (code !== 3'd2 || valid !== 1'b1) begin n_fail++; $display("FAIL prio_down got code=%0d valid=%b want 2 1", code, valid); end
    n_chk++; if (n_stb != 1 || n_rel != 0) begin n_fail++; $display("FAIL prio_down_pulses got strobe=%0d release=%0d want 1 0", n_stb, n_rel); end
  endtask

  task automatic test_release();
    int n;
    n_rel = 0;
    keys_n[2] = 1'b1;
    n = 0;
    while (keys_db[2] && n < 40) begin cyc(); n++; end
    n_chk++; if (n < 11 || n > 14 || keys_db !== 8'h00) begin n_fail++; $display("FAIL release_latency got %0d db=%h want 11..14 00", n, keys_db); end
    cyc();
    n_chk++; if (valid !== 1'b0 || key_release !== 1'b1) begin n_fail++; $display("FAIL release_edge got valid=%b release=%b want 0 1", valid, key_release); end
    n_chk++; if (code !== 3'd2) begin n_fail++; $display("FAIL release_code got %0d want 2", code); end
    cyc(6);
    n_chk++; if (n_rel != 1) begin n_fail++; $display("FAIL release_count got %0d want 1", n_rel); end
  endtask

  task automatic test_simultaneous();
    int n;
    n_stb = 0;
    keys_n[1] = 1'b0;
    keys_n[7] = 1'b0;
    n = 0;
    while (keys_db == 8'h00 && n < 40) begin cyc(); n++; end
    n_chk++; if (keys_db !== 8'h82) begin n_fail++; $display("FAIL simul_db got %h want 82", keys_db); end
    cyc();
    n_chk++; if (code !== 3'd7 || valid !== 1'b1) begin n_fail++; $display("FAIL simul_code got %0d valid=%b want 7 1", code, valid); end
    cyc(6);
    n_chk++; if (n_stb != 1) begin n_fail++; $display("FAIL simul_strobes got %0d want 1", n_stb); end
  endtask

  task automatic test_reset_mid();
    int n;
    keys_n = 8'b1110_1111;
    cyc(8);
    rst = 1'b0;
    #1;
    n_chk++; if (keys_db !== 8'h00 || code !== 3'd0 || valid !== 1'b0 || strobe !== 1'b0 || key_release !== 1'b0)
      begin n_fail++; $display("FAIL midreset_out got db=%h code=%0d v=%b s=%b r=%b want all 0", keys_db, code, valid, strobe, key_release); end
    cyc();
    rst = 1'b1;
    n = 0;
    while (!keys_db[4] && n < 40) begin cyc(); n++; end
    n_chk++; if (n < 11 || n > 15) begin n_fail++; $display("FAIL midreset_latency got %0d want 11..15", n); end
    n_chk++; if (keys_db !== 8'h10) begin n_fail++; $display("FAIL midreset_db got %h want 10", keys_db); end
  endtask

  task automatic test_random();
    int errs;
    do_reset();
    errs = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 24) == 0) keys_n[$urandom_range(0, 7)] ^= 1'b1;
      cyc();
      n_chk++;
      if (keys_db !== m_db || code !== m_code || valid !== m_val || strobe !== m_stb || key_release !== m_rel) begin
        n_fail++;
        if (errs++ < 10) $display("FAIL random_cycle%0d got db=%h c=%0d v=%b s=%b r=%b want db=%h c=%0d v=%b s=%b r=%b",
          c, keys_db, code, valid, strobe, key_release, m_db, m_code, m_val, m_stb, m_rel);
      end
      n_chk++; if (strobe && key_release) begin n_fail++; $display("FAIL random_both_pulses got 11 want not both"); end
    end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_bounce();
    test_priority();
    test_release();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
